scan_hex: RTL and testbench
===========================

// Module: scan_hex
// PURPOSE
// - Receive-side counterpart of the print path: turns UART bytes into a value for the debug unit's command logic.
// - Byte mode: returns the next raw byte.
// - Word mode: parses up to MAX_DIGITS ASCII hex digits, terminated by whitespace, into a 32-bit word.
// - Sits between the UART receiver (d_rx/vld_rx) and the command controller (req_rx/ack_rx four-phase handshake).
// PARAMETERS
// - MAX_DIGITS  8  max hex digits accepted per word (1..8); further digits are dropped and flagged.
// - DEL_EN      1  1: 0x7F (DEL) also acts as backspace; 0: 0x7F is an illegal char.
// PORTS
// - clk      in   1   system clock; everything is on posedge.
// - rstn     in   1   asynchronous, active-low reset.
// - type_rx  in   1   0 = byte request, 1 = word request; sampled when the request is accepted.
// - req_rx   in   1   request from the controller; held high until ack_rx is seen.
// - ack_rx   out  1   result valid; held high until req_rx falls.
// - din_rx   out  32  result: byte mode {24'b0,byte}; word mode the parsed value, right-aligned.
// - term_rx  out  8   terminator char that ended the word (0x20/0x0D/0x0A); 0x00 in byte mode.
// - err_rx   out  1   sticky per request: an illegal char or an overflow digit was seen.
// - d_rx     in   8   received byte from the UART receiver.
// - vld_rx   in   1   one-cycle pulse; d_rx is valid in that cycle.
// BEHAVIOUR
// - Async reset: state IDLE, ack_rx=0, din_rx=0, term_rx=0, err_rx=0, digit count=0.
// - States: IDLE, BYTE, WORD, ACK.
// - IDLE:
//   - If req_rx=1 and ack_rx=0: go to BYTE (type_rx=0) or WORD (type_rx=1).
//   - On entry to BYTE/WORD: clear din_rx, term_rx, err_rx and cnt.
//   - vld_rx pulses are discarded.
// - BYTE: on vld_rx, set din_rx <= {24'b0,d_rx} and go to ACK.
// - WORD: each vld_rx byte is classified:
//   - Hex digit ('0'-'9','A'-'F','a'-'f'):
//     - cnt<MAX_DIGITS: din_rx <= {din_rx[27:0],nibble}, cnt++.
//     - Otherwise: digit is dropped and err_rx<=1.
//   - Backspace (0x08, or 0x7F when DEL_EN=1):
//     - cnt>0: din_rx <= din_rx>>4, cnt--.
//     - cnt=0: ignored, no error.
//   - Terminator (0x20, 0x0D, 0x0A):
//     - cnt>0: term_rx<=d_rx, go to ACK.
//     - cnt=0: ignored, so leading whitespace is skipped.
//   - Any other byte: ignored and err_rx<=1.
// - Latency: ack_rx rises on the clock edge after the accepting vld_rx cycle.
// - ACK:
//   - ack_rx=1; din_rx, term_rx and err_rx are stable.
//   - vld_rx is discarded.
//   - When req_rx=0: ack_rx<=0 and go to IDLE; a new request is accepted no sooner than the following cycle.
// - Abort: req_rx=0 while in BYTE/WORD: go to IDLE, no ack, partial din_rx is cleared.
// - Reset mid-operation: returns to reset values at once; a partial word is lost.
// - type_rx changes after acceptance have no effect.
// TESTING
// - type=1, req=1, send "1A2b\r":
//   - ack_rx=1 one cycle after the '\r' pulse.
//   - din_rx=0x00001A2B, term_rx=0x0D, err_rx=0.
// - type=0, req=1, send 0x41:
//   - din_rx=0x00000041, ack_rx next cycle.
//   - Drop req: ack_rx=0 one cycle later.
// - type=1, send "  DEADBEEF5 ": din_rx=0xDEADBEEF, err_rx=1, term_rx=0x20.
// - type=1, send "\b12\b3\x7F4\n": din_rx=0x00000014, err_rx=0.
// - type=1, send "G7\n": din_rx=0x7, err_rx=1.
// - Mid-operation interruptions:
//   - Send "12", drop req: IDLE, ack never rises.
//   - New request then "5 ": din_rx=0x5.
//   - Assert rstn=0 mid-word: all outputs return to 0 immediately.

Source files
------------

// File: rtl/scan_hex.sv
// -----------------------------------------------------------------------------
// scan_hex
//
// Receive-side parser that sits between the UART receiver and the debug
// unit's command controller. On each accepted request it returns either the
// next raw byte (byte mode) or a 32-bit value built from up to MAX_DIGITS
// ASCII hex digits ended by whitespace (word mode).
//
// Parameters
//   MAX_DIGITS : hex digits kept per word (1..8); extra digits are dropped
//                and flagged on err_rx.
//   DEL_EN     : 1 = 0x7F (DEL) behaves like backspace, 0 = 0x7F is illegal.
//
// Ports
//   clk      in   1   system clock, all state on posedge
//   rstn     in   1   asynchronous active-low reset
//   type_rx  in   1   0 = byte request, 1 = word request (sampled on accept)
//   req_rx   in   1   request from controller, held until ack_rx is seen
//   ack_rx   out  1   result valid, held until req_rx falls
//   din_rx   out  32  result value, right-aligned
//   term_rx  out  8   terminator that ended a word, 0x00 in byte mode
//   err_rx   out  1   sticky per request: illegal char or overflow digit seen
//   d_rx     in   8   byte from the UART receiver
//   vld_rx   in   1   single-cycle strobe qualifying d_rx
// -----------------------------------------------------------------------------
module scan_hex #(
    parameter int MAX_DIGITS = 8,
    parameter bit DEL_EN     = 1'b1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        type_rx,
    input  logic        req_rx,
    output logic        ack_rx,
    output logic [31:0] din_rx,
    output logic [7:0]  term_rx,
    output logic        err_rx,
    input  logic [7:0]  d_rx,
    input  logic        vld_rx
);

    // Four bits hold any digit count from 0 to 8.
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DIGITS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BYTE = 2'd1,
        S_WORD = 2'd2,
        S_ACK  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        C_HEX  = 2'd0,
        C_BS   = 2'd1,
        C_TERM = 2'd2,
        C_ILL  = 2'd3
    } cls_t;

    // -------------------------------------------------------------------------
    // Character helpers
    // -------------------------------------------------------------------------
    function automatic cls_t classify(input logic [7:0] c);
        cls_t r;
        r = C_ILL;
        if ((c >= 8'h30 && c <= 8'h39) ||
            (c >= 8'h41 && c <= 8'h46) ||
            (c >= 8'h61 && c <= 8'h66)) begin
            r = C_HEX;
        end else if (c == 8'h08 || (DEL_EN && c == 8'h7F)) begin
            r = C_BS;
        end else if (c == 8'h20 || c == 8'h0D || c == 8'h0A) begin
            r = C_TERM;
        end
        return r;
    endfunction

    // Only valid for characters already classified as hex. Letters of either
    // case have low nibble 1..6, so adding 9 yields 10..15.
    function automatic logic [3:0] hex_nibble(input logic [7:0] c);
        logic [3:0] n;
        if (c <= 8'h39) begin
            n = c[3:0];
        end else begin
            n = c[3:0] + 4'd9;
        end
        return n;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t           state_q, state_d;
    logic             ack_q,   ack_d;
    logic [31:0]      din_q,   din_d;
    logic [7:0]       term_q,  term_d;
    logic             err_q,   err_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    cls_t       cls;
    logic [3:0] nib;

    assign cls = classify(d_rx);
    assign nib = hex_nibble(d_rx);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            ack_q   <= 1'b0;
            din_q   <= 32'h0;
            term_q  <= 8'h0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            din_q   <= din_d;
            term_q  <= term_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and datapath
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        ack_d   = ack_q;
        din_d   = din_q;
        term_d  = term_q;
        err_d   = err_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            S_IDLE: begin
                ack_d = 1'b0;
                // Received bytes are thrown away while no request is open.
                if (req_rx && !ack_q) begin
                    state_d = type_rx ? S_WORD : S_BYTE;
                    din_d   = 32'h0;
                    term_d  = 8'h0;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                end
            end

            S_BYTE: begin
                if (!req_rx) begin
                    // Controller withdrew the request: abandon quietly.
                    state_d = S_IDLE;
                    din_d   = 32'h0;
                    cnt_d   = '0;
                end else if (vld_rx) begin
                    din_d   = {24'h0, d_rx};
                    state_d = S_ACK;
                    ack_d   = 1'b1;
                end
            end

            S_WORD: begin
                if (!req_rx) begin
                    state_d = S_IDLE;
                    din_d   = 32'h0;
                    cnt_d   = '0;
                end else if (vld_rx) begin
                    unique case (cls)
                        C_HEX: begin
                            if (cnt_q < CNT_MAX) begin
                                din_d = {din_q[27:0], nib};
                                cnt_d = cnt_q + 1'b1;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        C_BS: begin
                            // Backspace on an empty word is harmless.
                            if (cnt_q != '0) begin
                                din_d = din_q >> 4;
                                cnt_d = cnt_q - 1'b1;
                            end
                        end
                        C_TERM: begin
                            // Whitespace before the first digit is skipped.
                            if (cnt_q != '0) begin
                                term_d  = d_rx;
                                state_d = S_ACK;
                                ack_d   = 1'b1;
                            end
                        end
                        default: begin
                            err_d = 1'b1;
                        end
                    endcase
                end
            end

            S_ACK: begin
                ack_d = 1'b1;
                // Result stays frozen; bytes arriving now are discarded.
                if (!req_rx) begin
                    ack_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
                ack_d   = 1'b0;
            end
        endcase
    end

    assign ack_rx  = ack_q;
    assign din_rx  = din_q;
    assign term_rx = term_q;
    assign err_rx  = err_q;

endmodule

// File: tb/tb_scan_hex.sv
// -----------------------------------------------------------------------------
// tb_scan_hex
//
// Directed bench for scan_hex: drives request/handshake and UART byte strobes
// on the falling clock edge, samples DUT outputs on the falling edge, and
// compares against hand-computed values.
// -----------------------------------------------------------------------------
module tb_scan_hex;

    logic        clk;
    logic        rstn;
    logic        type_rx;
    logic        req_rx;
    logic        ack_rx;
    logic [31:0] din_rx;
    logic [7:0]  term_rx;
    logic        err_rx;
    logic [7:0]  d_rx;
    logic        vld_rx;

    int n_vec;
    int n_miss;

    scan_hex #(
        .MAX_DIGITS(8),
        .DEL_EN    (1'b1)
    ) dut (
        .clk    (clk),
        .rstn   (rstn),
        .type_rx(type_rx),
        .req_rx (req_rx),
        .ack_rx (ack_rx),
        .din_rx (din_rx),
        .term_rx(term_rx),
        .err_rx (err_rx),
        .d_rx   (d_rx),
        .vld_rx (vld_rx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    // All helpers are entered and left at a falling edge.
    task automatic send_byte(input logic [7:0] b);
        d_rx   = b;
        vld_rx = 1'b1;
        @(negedge clk);
        vld_rx = 1'b0;
        d_rx   = 8'h00;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i]);
        end
    endtask

    task automatic start_req(input logic t);
        type_rx = t;
        req_rx  = 1'b1;
        @(negedge clk);
    endtask

    task automatic drop_req();
        req_rx = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        n_vec   = 0;
        n_miss  = 0;
        rstn    = 1'b0;
        type_rx = 1'b0;
        req_rx  = 1'b0;
        d_rx    = 8'h00;
        vld_rx  = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_ack",  {31'h0, ack_rx}, 32'h0);
        chk("rst_din",  din_rx,          32'h0);
        chk("rst_term", {24'h0, term_rx}, 32'h0);
        chk("rst_err",  {31'h0, err_rx}, 32'h0);
        rstn = 1'b1;
        @(negedge clk);

        // Bytes while idle must not start anything.
        send_byte(8'h31);
        chk("idle_ack", {31'h0, ack_rx}, 32'h0);

        // Word "1A2b\r"
        start_req(1'b1);
        send_str("1A2b");
        chk("w1_ack_pre", {31'h0, ack_rx}, 32'h0);
        send_byte(8'h0D);
        chk("w1_ack",  {31'h0, ack_rx}, 32'h1);
        chk("w1_din",  din_rx,          32'h00001A2B);
        chk("w1_term", {24'h0, term_rx}, 32'h0000000D);
        chk("w1_err",  {31'h0, err_rx}, 32'h0);
        drop_req();
        chk("w1_ack_drop", {31'h0, ack_rx}, 32'h0);

        // Byte 0x41; a byte arriving during ACK must not disturb the result.
        start_req(1'b0);
        send_byte(8'h41);
        chk("b_ack",  {31'h0, ack_rx}, 32'h1);
        chk("b_din",  din_rx,          32'h00000041);
        chk("b_term", {24'h0, term_rx}, 32'h0);
        send_byte(8'h55);
        chk("b_hold", din_rx,          32'h00000041);
        drop_req();
        chk("b_ack_drop", {31'h0, ack_rx}, 32'h0);

        // Leading spaces, eight digits, one overflow digit, space terminator.
        start_req(1'b1);
        send_str("  DEADBEEF5 ");
        chk("ovf_ack",  {31'h0, ack_rx}, 32'h1);
        chk("ovf_din",  din_rx,          32'hDEADBEEF);
        chk("ovf_err",  {31'h0, err_rx}, 32'h1);
        chk("ovf_term", {24'h0, term_rx}, 32'h00000020);
        drop_req();

        // Backspace / DEL editing: "\b12\b3\x7F4\n"
        start_req(1'b1);
        send_byte(8'h08);
        send_str("12");
        send_byte(8'h08);
        send_str("3");
        send_byte(8'h7F);
        send_str("4");
        send_byte(8'h0A);
        chk("bs_ack",  {31'h0, ack_rx}, 32'h1);
        chk("bs_din",  din_rx,          32'h00000014);
        chk("bs_err",  {31'h0, err_rx}, 32'h0);
        chk("bs_term", {24'h0, term_rx}, 32'h0000000A);
        drop_req();

        // Illegal character: "G7\n"
        start_req(1'b1);
        send_str("G7");
        send_byte(8'h0A);
        chk("ill_din", din_rx,          32'h00000007);
        chk("ill_err", {31'h0, err_rx}, 32'h1);
        drop_req();

        // Abort mid-word, then a fresh request.
        start_req(1'b1);
        send_str("12");
        chk("ab_part", din_rx, 32'h00000012);
        drop_req();
        chk("ab_din", din_rx,          32'h0);
        chk("ab_ack", {31'h0, ack_rx}, 32'h0);
        repeat (3) @(negedge clk);
        chk("ab_ack_late", {31'h0, ack_rx}, 32'h0);
        start_req(1'b1);
        send_str("5 ");
        chk("re_ack", {31'h0, ack_rx}, 32'h1);
        chk("re_din", din_rx,          32'h00000005);
        chk("re_err", {31'h0, err_rx}, 32'h0);
        drop_req();

        // Asynchronous reset in the middle of a word.
        start_req(1'b1);
        send_str("AB");
        chk("mr_part", din_rx, 32'h000000AB);
        rstn = 1'b0;
        #1;
        chk("mr_din", din_rx,          32'h0);
        chk("mr_ack", {31'h0, ack_rx}, 32'h0);
        chk("mr_err", {31'h0, err_rx}, 32'h0);
        @(negedge clk);
        req_rx = 1'b0;
        rstn   = 1'b1;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
